// File: rtl/piho_real_if.sv
// rtl/piho_real_if.sv - configuration and result bundle of the path-integral Monte-Carlo core
interface piho_real_if;
    logic [119:0] seed;
    logic [31:0]  MCNconf;
    logic [31:0]  MCNdump;
    logic [31:0]  looptimes;
    logic [63:0]  x2sum1;
    logic [63:0]  x2sum2;
    logic [63:0]  x2sum3;
    logic [63:0]  x2sum4;
    logic [63:0]  x2sumall;
    logic         finish;

    modport master (
        output seed, MCNconf, MCNdump,
        input  looptimes, x2sum1, x2sum2, x2sum3, x2sum4, x2sumall, finish
    );

    modport slave (
        input  seed, MCNconf, MCNdump,
        output looptimes, x2sum1, x2sum2, x2sum3, x2sum4, x2sumall, finish
    );
endinterface

// File: rtl/piho_real_top.sv
// rtl/piho_real_top.sv - four-lane Metropolis engine for the path-integral harmonic oscillator
module piho_real_top #(
    parameter int          NSITE = 16,
    parameter logic [15:0] DELTA = 16'h0800
) (
    input  logic       clk,
    input  logic       rst,
    piho_real_if.slave bus
);
    localparam int LANES = 4;
    localparam int IW    = $clog2(NSITE);

    typedef enum logic [2:0] {START, THERM, MEAS, ACC, DONE} state_t;

    state_t                state, state_nx;
    logic signed [15:0]    x [LANES][NSITE];
    logic [31:0]           rng [LANES];
    logic signed [15:0]    xp [LANES];
    logic signed [15:0]    xp_r [LANES];
    logic signed [39:0]    ds [LANES];
    logic signed [39:0]    ds_r [LANES];
    logic [6:0]            kidx [LANES];
    logic                  accept [LANES];
    logic [63:0]           sum [LANES];
    logic [15:0]           acc_rom [128];
    logic [IW-1:0]         site, site_l, site_r;
    logic                  phase, sweep_end, site_end;
    logic [31:0]           conf_n, dump_n, therm_cnt, meas_cnt, loops;

    function automatic logic [31:0] xorshift(input logic [31:0] s0);
        logic [31:0] s;
        s = s0 ^ (s0 << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    function automatic logic signed [15:0] propose(input logic signed [15:0] xc, input logic [31:0] s);
        logic signed [15:0] r;
        logic signed [32:0] prod;
        logic signed [18:0] nx;
        r    = $signed({~s[15], s[14:0]});
        prod = 33'(r) * 33'($signed({1'b0, DELTA}));
        nx   = 19'(xc) + 19'(prod >>> 15);
        if (nx > 19'sd32767)
            return 16'sh7fff;
        else if (nx < -19'sd32768)
            return 16'sh8000;
        else
            return nx[15:0];
    endfunction

    // Local action of one site, Q8.24, halved with truncation.
    function automatic logic [35:0] lfun(input logic signed [15:0] y, input logic signed [15:0] yl,
                                         input logic signed [15:0] yr);
        logic signed [16:0] a, b;
        logic signed [33:0] sa, sb, sy;
        logic [35:0]        tot;
        a   = 17'(yr) - 17'(y);
        b   = 17'(y) - 17'(yl);
        sa  = 34'(a) * 34'(a);
        sb  = 34'(b) * 34'(b);
        sy  = 34'(y) * 34'(y);
        tot = 36'(sa) + 36'(sb) + 36'(sy);
        return tot >> 1;
    endfunction

    function automatic logic [31:0] sq32(input logic signed [15:0] y);
        logic signed [31:0] p;
        p = 32'(y) * 32'(y);
        return p;
    endfunction

    // Elaboration-time acceptance table: exp(-1/16) from its series in Q0.62, raised to k.
    function automatic logic [15:0] acc_entry(input logic [6:0] k);
        logic [127:0] term, r, p, v;
        term = 128'd1 << 62;
        r    = term;
        for (int n = 1; n <= 12; n++) begin
            term = term / (128'(n) << 4);
            r    = n[0] ? r - term : r + term;
        end
        v = 128'd1 << 62;
        p = r;
        for (int b = 0; b < 7; b++) begin
            if (k[b])
                v = (v * p) >> 62;
            p = (p * p) >> 62;
        end
        v = (v * 128'd65535 + (128'd1 << 61)) >> 62;
        return v[15:0];
    endfunction

    for (genvar g = 0; g < 128; g++) begin : g_rom
        assign acc_rom[g] = acc_entry(7'(g));
    end

    assign site_l    = site - IW'(1);
    assign site_r    = site + IW'(1);
    assign site_end  = (site == IW'(NSITE - 1));
    assign sweep_end = phase && site_end;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            xp[l]     = propose(x[l][site], rng[l]);
            ds[l]     = $signed({4'b0, lfun(xp[l], x[l][site_l], x[l][site_r])})
                      - $signed({4'b0, lfun(x[l][site], x[l][site_l], x[l][site_r])});
            kidx[l]   = (ds_r[l][39:27] != '0) ? 7'd127 : ds_r[l][26:20];
            accept[l] = ds_r[l][39] || (ds_r[l] == '0) || (rng[l][31:16] < acc_rom[kidx[l]]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            START: begin
                if (bus.MCNdump != '0)
                    state_nx = THERM;
                else if (bus.MCNconf != '0)
                    state_nx = MEAS;
                else
                    state_nx = DONE;
            end
            THERM: if (sweep_end && (therm_cnt + 32'd1 == dump_n))
                       state_nx = (conf_n != '0) ? MEAS : DONE;
            MEAS:  if (sweep_end)
                       state_nx = ACC;
            ACC:   if (site_end)
                       state_nx = (meas_cnt + 32'd1 == conf_n) ? DONE : MEAS;
            DONE:  state_nx = DONE;
            default: state_nx = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= START;
            site      <= '0;
            phase     <= 1'b0;
            conf_n    <= '0;
            dump_n    <= '0;
            therm_cnt <= '0;
            meas_cnt  <= '0;
            loops     <= '0;
            for (int l = 0; l < LANES; l++) begin
                rng[l]  <= {2'b01, bus.seed[30*l +: 30]};
                xp_r[l] <= '0;
                ds_r[l] <= '0;
                sum[l]  <= '0;
                for (int i = 0; i < NSITE; i++)
                    x[l][i] <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                START: begin
                    conf_n <= bus.MCNconf;
                    dump_n <= bus.MCNdump;
                    site   <= '0;
                    phase  <= 1'b0;
                end
                THERM, MEAS: begin
                    phase <= ~phase;
                    if (!phase) begin
                        for (int l = 0; l < LANES; l++) begin
                            xp_r[l] <= xp[l];
                            ds_r[l] <= ds[l];
                        end
                    end else begin
                        site <= site_r;
                        for (int l = 0; l < LANES; l++) begin
                            if (accept[l])
                                x[l][site] <= xp_r[l];
                            rng[l] <= xorshift(rng[l]);
                        end
                    end
                    if (sweep_end) begin
                        loops <= loops + 32'd1;
                        if (state == THERM)
                            therm_cnt <= therm_cnt + 32'd1;
                    end
                end
                ACC: begin
                    site <= site_r;
                    for (int l = 0; l < LANES; l++)
                        sum[l] <= sum[l] + {32'b0, sq32(x[l][site])};
                    if (site_end)
                        meas_cnt <= meas_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.looptimes = loops;
    assign bus.x2sum1    = sum[0];
    assign bus.x2sum2    = sum[1];
    assign bus.x2sum3    = sum[2];
    assign bus.x2sum4    = sum[3];
    assign bus.x2sumall  = sum[0] + sum[1] + sum[2] + sum[3];
    assign bus.finish    = (state == DONE);
endmodule

// File: tb/tb_piho_real_top.sv
// tb/tb_piho_real_top.sv - scoreboard bench for piho_real_top against a behavioural golden model
module tb_piho_real_top;
    localparam int NSITE = 16;
    localparam int DELTA = 2048;

    typedef struct {
        int          cycles;
        logic [31:0] loops;
        logic [63:0] s1, s2, s3, s4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piho_real_if bus();

    piho_real_top #(.NSITE(NSITE), .DELTA(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] rom [128];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] s0);
        logic [31:0] s;
        s = s0 ^ (s0 << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    function automatic longint lval(input int y, input int yl, input int yr);
        longint a, b, c;
        a = longint'(yr - y);
        b = longint'(y - yl);
        c = longint'(y);
        return (a * a + b * b + c * c) / 2;
    endfunction

    function automatic exp_t model(input logic [119:0] sd, input logic [31:0] conf, input logic [31:0] dump);
        exp_t        e;
        logic [63:0] acc [4];
        int          xs [NSITE];
        logic [31:0] s;
        int          r, step, xn, xl, xr, k;
        longint      dsv;
        bit          ok;
        for (int l = 0; l < 4; l++) begin
            s      = {2'b01, sd[30*l +: 30]};
            acc[l] = '0;
            for (int i = 0; i < NSITE; i++) xs[i] = 0;
            for (longint sw = 0; sw < longint'(dump) + longint'(conf); sw++) begin
                for (int i = 0; i < NSITE; i++) begin
                    r    = int'(s[15:0]) - 32768;
                    step = (r * DELTA) >>> 15;
                    xn   = xs[i] + step;
                    if (xn > 32767) xn = 32767;
                    if (xn < -32768) xn = -32768;
                    xl  = xs[(i + NSITE - 1) % NSITE];
                    xr  = xs[(i + 1) % NSITE];
                    dsv = lval(xn, xl, xr) - lval(xs[i], xl, xr);
                    if (dsv <= 0) begin
                        ok = 1'b1;
                    end else begin
                        k  = ((dsv >> 20) > 127) ? 127 : int'(dsv >> 20);
                        ok = (s[31:16] < rom[k]);
                    end
                    if (ok) xs[i] = xn;
                    s = xs32(s);
                end
                if (sw >= longint'(dump))
                    for (int i = 0; i < NSITE; i++)
                        acc[l] += 64'(longint'(xs[i]) * longint'(xs[i]));
            end
        end
        e.cycles = 1 + (int'(dump) + int'(conf)) * 2 * NSITE + int'(conf) * NSITE;
        e.loops  = dump + conf;
        e.s1 = acc[0];
        e.s2 = acc[1];
        e.s3 = acc[2];
        e.s4 = acc[3];
        return e;
    endfunction

    task automatic apply(input logic [119:0] sd, input logic [31:0] conf, input logic [31:0] dump);
        @(negedge clk);
        rst         = 1'b0;
        bus.seed    = sd;
        bus.MCNconf = conf;
        bus.MCNdump = dump;
        sb_q.push_back(model(sd, conf, dump));
        repeat (2) @(negedge clk);
    endtask

    task automatic release_and_wait(input string tag);
        int   cnt;
        exp_t e;
        rst = 1'b1;
        cnt = 0;
        while (bus.finish !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        e = sb_q.pop_front();
        check({tag, "_finish_cycle"}, 64'(cnt), 64'(e.cycles));
        check({tag, "_looptimes"}, 64'(bus.looptimes), 64'(e.loops));
        check({tag, "_x2sum1"}, bus.x2sum1, e.s1);
        check({tag, "_x2sum2"}, bus.x2sum2, e.s2);
        check({tag, "_x2sum3"}, bus.x2sum3, e.s3);
        check({tag, "_x2sum4"}, bus.x2sum4, e.s4);
        check({tag, "_x2sumall"}, bus.x2sumall, e.s1 + e.s2 + e.s3 + e.s4);
        repeat (6) @(negedge clk);
        check({tag, "_hold_finish"}, 64'(bus.finish), 64'd1);
        check({tag, "_hold_looptimes"}, 64'(bus.looptimes), 64'(e.loops));
    endtask

    localparam logic [119:0] SPEC_SEED = 120'h1234FF00EE_FF01234990_99FAAAB778;

    initial begin
        logic [127:0] rs;
        for (int k = 0; k < 128; k++)
            rom[k] = 16'($rtoi(65535.0 * $exp(-k / 16.0) + 0.5));

        bus.seed    = SPEC_SEED;
        bus.MCNconf = 32'd3;
        bus.MCNdump = 32'd2;
        repeat (3) @(negedge clk);
        check("rst_looptimes", 64'(bus.looptimes), 64'd0);
        check("rst_x2sum1", bus.x2sum1, 64'd0);
        check("rst_x2sum2", bus.x2sum2, 64'd0);
        check("rst_x2sum3", bus.x2sum3, 64'd0);
        check("rst_x2sum4", bus.x2sum4, 64'd0);
        check("rst_x2sumall", bus.x2sumall, 64'd0);
        check("rst_finish", 64'(bus.finish), 64'd0);

        apply(SPEC_SEED, 32'd3, 32'd2);
        release_and_wait("base");

        apply(SPEC_SEED, 32'd3, 32'd2);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_looptimes", 64'(bus.looptimes), 64'd0);
        check("midrst_x2sumall", bus.x2sumall, 64'd0);
        check("midrst_finish", 64'(bus.finish), 64'd0);
        release_and_wait("restart");

        apply(SPEC_SEED, 32'd0, 32'd4);
        release_and_wait("conf0");

        apply(SPEC_SEED, 32'd1, 32'd0);
        release_and_wait("dump0");

        apply(SPEC_SEED, 32'd0, 32'd0);
        release_and_wait("both0");

        for (int n = 0; n < 20; n++) begin
            rs = {$urandom, $urandom, $urandom, $urandom};
            apply(rs[119:0], 32'd10, 32'd5);
            release_and_wait($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
